wb_axis_stream_bridge: RTL

//  Wishbone-slave front end placed directly upstream/downstream of the FIR core.
//  CPU writes of x[n] go into an X FIFO drained onto the FIR AXI-Stream slave (ss_*).
//  FIR outputs y[n] (sm_*) go into a Y FIFO read back over Wishbone.

---
 rtl/wb_axis_stream_bridge.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/wb_axis_stream_bridge.sv
// Wishbone slave that buffers CPU-written x[n] samples onto the FIR AXI-Stream input
// and buffers FIR y[n] outputs for Wishbone read-back, with a status word.
module wb_axis_stream_bridge #(
  parameter int unsigned DEPTH     = 8,
  parameter logic [31:0] X_ADDR    = 32'h3000_0080,
  parameter logic [31:0] Y_ADDR    = 32'h3000_0088,
  parameter logic [31:0] STAT_ADDR = 32'h3000_008C
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        hit_o,
  input  logic [31:0] data_len,
  output logic        ss_tvalid,
  output logic [31:0] ss_tdata,
  output logic        ss_tlast,
  input  logic        ss_tready,
  input  logic        sm_tvalid,
  input  logic [31:0] sm_tdata,
  input  logic        sm_tlast,
  output logic        sm_tready
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0] x_mem [DEPTH];
  logic [32:0] y_mem [DEPTH];

  logic [AW-1:0] x_wr_q, x_wr_d, x_rd_q, x_rd_d;
  logic [AW-1:0] y_wr_q, y_wr_d, y_rd_q, y_rd_d;
  logic [CW-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [31:0]   frame_q, frame_d;
  logic          ack_q, ack_d;
  logic [31:0]   dat_q, dat_d;
  logic          last_seen_q, last_seen_d;

  logic          x_full, x_empty, y_full, y_empty;
  logic          sel_x, sel_y, sel_stat, req;
  logic          x_push, x_pop, y_push, y_pop;
  logic [31:0]   len_m1;
  logic [15:0]   x_cnt_ext, y_cnt_ext;
  logic [31:0]   stat_word;

  assign x_full  = (x_cnt_q == FULL_CNT);
  assign x_empty = (x_cnt_q == '0);
  assign y_full  = (y_cnt_q == FULL_CNT);
  assign y_empty = (y_cnt_q == '0);

  assign sel_x    = (wbs_adr_i == X_ADDR);
  assign sel_y    = (wbs_adr_i == Y_ADDR);
  assign sel_stat = (wbs_adr_i == STAT_ADDR);
  assign hit_o    = wbs_stb_i & wbs_cyc_i & (sel_x | sel_y | sel_stat);
  // Masking with the pending ack guarantees at least one idle cycle between acks.
  assign req      = hit_o & ~ack_q;

  assign ss_tvalid = ~x_empty;
  assign ss_tdata  = x_mem[x_rd_q];
  assign x_pop     = ss_tvalid & ss_tready;
  assign sm_tready = ~y_full;
  assign y_push    = sm_tvalid & sm_tready;

  // A zero frame length behaves as a one-sample frame.
  assign len_m1   = (data_len == 32'd0) ? 32'd0 : data_len - 32'd1;
  assign ss_tlast = (frame_q == len_m1);

  assign x_cnt_ext = 16'(x_cnt_q);
  assign y_cnt_ext = 16'(y_cnt_q);
  assign stat_word = {8'h00, y_cnt_ext[7:0], x_cnt_ext[7:0], 3'b000,
                      last_seen_q, y_empty, y_full, x_empty, x_full};

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

  always_comb begin
    ack_d       = 1'b0;
    dat_d       = dat_q;
    last_seen_d = last_seen_q;
    x_push      = 1'b0;
    y_pop       = 1'b0;
    if (req) begin
      if (sel_x && wbs_we_i) begin
        if (wbs_sel_i != 4'hF) begin
          ack_d = 1'b1;
          dat_d = 32'd0;
        end else if (!x_full || x_pop) begin
          // A same-edge stream pop frees the slot this write needs.
          x_push = 1'b1;
          ack_d  = 1'b1;
          dat_d  = 32'd0;
        end
      end else if (sel_y && !wbs_we_i) begin
        if (!y_empty) begin
          y_pop = 1'b1;
          ack_d = 1'b1;
          dat_d = y_mem[y_rd_q][31:0];
          if (y_mem[y_rd_q][32]) last_seen_d = 1'b1;
        end
      end else if (sel_stat && !wbs_we_i) begin
        ack_d       = 1'b1;
        dat_d       = stat_word;
        last_seen_d = 1'b0;
      end else begin
        ack_d = 1'b1;
        dat_d = 32'd0;
      end
    end
  end

  always_comb begin
    x_wr_d  = x_wr_q + AW'(x_push);
    x_rd_d  = x_rd_q + AW'(x_pop);
    x_cnt_d = x_cnt_q + CW'(x_push) - CW'(x_pop);
    y_wr_d  = y_wr_q + AW'(y_push);
    y_rd_d  = y_rd_q + AW'(y_pop);
    y_cnt_d = y_cnt_q + CW'(y_push) - CW'(y_pop);
    frame_d = frame_q;
    if (x_pop) frame_d = ss_tlast ? 32'd0 : frame_q + 32'd1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (x_push) x_mem[x_wr_q] <= wbs_dat_i;
    if (y_push) y_mem[y_wr_q] <= {sm_tlast, sm_tdata};
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      x_wr_q      <= '0;
      x_rd_q      <= '0;
      x_cnt_q     <= '0;
      y_wr_q      <= '0;
      y_rd_q      <= '0;
      y_cnt_q     <= '0;
      frame_q     <= '0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      last_seen_q <= 1'b0;
    end else begin
      x_wr_q      <= x_wr_d;
      x_rd_q      <= x_rd_d;
      x_cnt_q     <= x_cnt_d;
      y_wr_q      <= y_wr_d;
      y_rd_q      <= y_rd_d;
      y_cnt_q     <= y_cnt_d;
      frame_q     <= frame_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      last_seen_q <= last_seen_d;
    end
  end

endmodule
